ex_mem_issue_reg: RTL

- Dual-lane EX/MEM pipeline register sitting directly upstream of the dual-port memory stage.
- Captures both execute-lane results every cycle and drives the memory-stage control, address and write-data inputs.
- Detects same-word memory conflicts between the lanes and serializes the pair over two cycles, stalling execute for the second cycle.
- Guarantees program order for store/load and store/store pairs to the same word.

---
 rtl/mips_pipe_pkg.sv | 37 +++
 rtl/mem_conflict_detect.sv | 26 ++
 rtl/ex_mem_issue_reg.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the dual-lane MIPS core: lane payload, issue state,
// and the helper that squashes control bits on an invalid lane.
package mips_pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    PASS  = 1'b0,
    SPLIT = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic [REG_W-1:0]  writereg;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] writedata;
  } lane_t;

  localparam lane_t BUBBLE = '0;

  // An invalid lane may carry stale control bits; never let them reach memory.
  function automatic lane_t sanitize(input lane_t l);
    lane_t s;
    s = l;
    if (!l.valid) begin
      s.regwrite = 1'b0;
      s.memtoreg = 1'b0;
      s.memwrite = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_conflict_detect.sv
// Same-word memory conflict between two lanes: both valid memory accesses,
// at least one a store, identical word address above ADDR_LSB.
module mem_conflict_detect
  import mips_pipe_pkg::*;
#(
  parameter int unsigned ADDR_LSB = 2
) (
  input  lane_t lane_a,
  input  lane_t lane_b,
  output logic  conflict_c
);

  logic mem_a;
  logic mem_b;
  logic any_store;
  logic same_word;

  assign mem_a     = lane_a.memtoreg | lane_a.memwrite;
  assign mem_b     = lane_b.memtoreg | lane_b.memwrite;
  assign any_store = lane_a.memwrite | lane_b.memwrite;
  assign same_word = (lane_a.aluout[DATA_W-1:ADDR_LSB] == lane_b.aluout[DATA_W-1:ADDR_LSB]);

  // Two loads to one word are harmless on a dual-port RAM.
  assign conflict_c = lane_a.valid & lane_b.valid & mem_a & mem_b & any_store & same_word;

endmodule

// File: rtl/ex_mem_issue_reg.sv
// Dual-lane EX/MEM register; serializes same-word lane pairs over two cycles.
// Optional MEM_SPLIT_COUNT_EN adds a 32-bit split_count of PASS->SPLIT events.
module ex_mem_issue_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              holdm,
  input  logic              flushm,
  input  logic              valide,
  input  logic              valide2,
  input  logic              regwritee,
  input  logic              regwritee2,
  input  logic              memtorege,
  input  logic              memtorege2,
  input  logic              memwritee,
  input  logic              memwritee2,
  input  logic [REG_W-1:0]  writerege,
  input  logic [REG_W-1:0]  writerege2,
  input  logic [DATA_W-1:0] aluoute,
  input  logic [DATA_W-1:0] aluoute2,
  input  logic [DATA_W-1:0] writedatae,
  input  logic [DATA_W-1:0] writedatae2,
  output logic              stalle,
  output logic              validm,
  output logic              validm2,
  output logic              regwritem,
  output logic              regwritem2,
  output logic              memtoregm,
  output logic              memtoregm2,
  output logic              memwritem,
  output logic              memwritem2,
  output logic [REG_W-1:0]  writeregm,
  output logic [REG_W-1:0]  writeregm2,
  output logic [DATA_W-1:0] aluoutm,
  output logic [DATA_W-1:0] aluoutm2,
  output logic [DATA_W-1:0] writedatam,
  output logic [DATA_W-1:0] writedatam2
`ifdef MEM_SPLIT_COUNT_EN
  ,
  output logic [31:0]       split_count
`endif
);

  lane_t        raw_e;
  lane_t        raw_e2;
  lane_t        lane_e;
  lane_t        lane_e2;
  logic         conflict_c;
  issue_state_t state_q;
  issue_state_t state_d;
  lane_t        lane1_q;
  lane_t        lane1_d;
  lane_t        lane2_q;
  lane_t        lane2_d;
  lane_t        stash_q;
  lane_t        stash_d;

  // Bundle execute-stage inputs into lane payloads.
  always_comb begin
    raw_e.valid      = valide;
    raw_e.regwrite   = regwritee;
    raw_e.memtoreg   = memtorege;
    raw_e.memwrite   = memwritee;
    raw_e.writereg   = writerege;
    raw_e.aluout     = aluoute;
    raw_e.writedata  = writedatae;
    raw_e2.valid     = valide2;
    raw_e2.regwrite  = regwritee2;
    raw_e2.memtoreg  = memtorege2;
    raw_e2.memwrite  = memwritee2;
    raw_e2.writereg  = writerege2;
    raw_e2.aluout    = aluoute2;
    raw_e2.writedata = writedatae2;
  end

  assign lane_e  = sanitize(raw_e);
  assign lane_e2 = sanitize(raw_e2);

  mem_conflict_detect #(
    .ADDR_LSB (ADDR_LSB)
  ) u_conflict (
    .lane_a     (lane_e),
    .lane_b     (lane_e2),
    .conflict_c (conflict_c)
  );

`ifdef MEM_SPLIT_COUNT_EN
  logic [31:0] count_q;
  logic [31:0] count_d;
`endif

  // State, output lanes and stash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PASS;
      lane1_q <= BUBBLE;
      lane2_q <= BUBBLE;
      stash_q <= BUBBLE;
`ifdef MEM_SPLIT_COUNT_EN
      count_q <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
      stash_q <= stash_d;
`ifdef MEM_SPLIT_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  // Next-state: in SPLIT the execute inputs are ignored; the stash drives lane 2.
  always_comb begin
    state_d = state_q;
    lane1_d = lane1_q;
    lane2_d = lane2_q;
    stash_d = stash_q;
`ifdef MEM_SPLIT_COUNT_EN
    count_d = count_q;
`endif
    case (state_q)
      PASS: begin
        if (holdm) begin
          state_d = PASS;
        end else if (flushm) begin
          lane1_d = BUBBLE;
          lane2_d = BUBBLE;
        end else if (conflict_c) begin
          lane1_d = lane_e;
          lane2_d = BUBBLE;
          stash_d = lane_e2;
          state_d = SPLIT;
`ifdef MEM_SPLIT_COUNT_EN
          count_d = count_q + 32'd1;
`endif
        end else begin
          lane1_d = lane_e;
          lane2_d = lane_e2;
        end
      end
      SPLIT: begin
        if (holdm) begin
          state_d = SPLIT;
        end else if (flushm) begin
          lane1_d = BUBBLE;
          lane2_d = BUBBLE;
          stash_d = BUBBLE;
          state_d = PASS;
        end else begin
          lane1_d = BUBBLE;
          lane2_d = stash_q;
          stash_d = BUBBLE;
          state_d = PASS;
        end
      end
      default: begin
        state_d = PASS;
      end
    endcase
  end

  assign stalle = (state_q == SPLIT);

  assign validm      = lane1_q.valid;
  assign regwritem   = lane1_q.regwrite;
  assign memtoregm   = lane1_q.memtoreg;
  assign memwritem   = lane1_q.memwrite;
  assign writeregm   = lane1_q.writereg;
  assign aluoutm     = lane1_q.aluout;
  assign writedatam  = lane1_q.writedata;
  assign validm2     = lane2_q.valid;
  assign regwritem2  = lane2_q.regwrite;
  assign memtoregm2  = lane2_q.memtoreg;
  assign memwritem2  = lane2_q.memwrite;
  assign writeregm2  = lane2_q.writereg;
  assign aluoutm2    = lane2_q.aluout;
  assign writedatam2 = lane2_q.writedata;

`ifdef MEM_SPLIT_COUNT_EN
  assign split_count = count_q;
`endif

endmodule
